// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the instruction-phase sequencer.
package cpu_seq_pkg;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] HALT_PHASE = 3'd4;
  localparam logic [PHASE_W-1:0] LAST_PHASE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_sequencer_phase_counter.sv
// 3-bit instruction phase register; clear wins over enable, wraps 7 -> 0.
module phase_counter
  import cpu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_,
  input  logic               en,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr)     phase_d = '0;
    else if (en) phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Run/step/stop control FSM sequencing 8-phase instructions, with memory
// wait timeout, halt handling and a retired-instruction counter.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               run,
  input  logic               step,
  input  logic               stop,
  input  logic               halt,
  input  logic               rd,
  input  logic               wr,
  input  logic               mem_ready,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               bus_err,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W:0] WAIT_LIM = (WAIT_W+1)'(WAIT_MAX);

  state_e             state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;

  logic               active, mem_stall, halt_hit, adv, retire, timeout;
  logic [WAIT_W:0]    wait_inc;

  phase_counter u_phase (
    .clk   (clk),
    .rst_  (rst_),
    .en    (adv),
    .clr   (state_q == ST_IDLE),
    .phase (phase)
  );

  always_comb begin
    active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    mem_stall = (rd | wr) & ~mem_ready;
    halt_hit  = active & halt & (phase == HALT_PHASE);
    adv       = active & ~mem_stall & ~halt_hit;
    retire    = adv & (phase == LAST_PHASE);
    wait_inc  = {1'b0, wait_q} + 1'b1;
    // Halt at phase 4 outranks a timeout landing in the same cycle.
    timeout   = active & mem_stall & ~halt_hit & (wait_inc == WAIT_LIM);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    bus_err_d   = bus_err_q;
    wait_d      = wait_q;
    cnt_d       = retire ? cnt_q + 1'b1 : cnt_q;

    if (adv)                         wait_d = '0;
    else if (active && mem_stall && !halt_hit) wait_d = wait_inc[WAIT_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (run)       state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_hit) state_d = ST_HALTED;
        else if (timeout) begin
          state_d   = ST_HALTED;
          bus_err_d = 1'b1;
        end else begin
          if (stop) stop_pend_d = 1'b1;
          if (retire && (stop_pend_q || stop)) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      ST_STEP: begin
        if (halt_hit) state_d = ST_HALTED;
        else if (timeout) begin
          state_d   = ST_HALTED;
          bus_err_d = 1'b1;
        end else if (retire) state_d = ST_IDLE;
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they flop in step with it.
  always_comb begin
    running_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    halted_d  = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      wait_q      <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      wait_q      <= wait_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  assign running   = running_q;
  assign halted    = halted_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

endmodule
